// File: rtl/spm_pkg.sv
// Shared types and sizing helpers for the serial-parallel multiplier.
package spm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } spm_state_t;

    // Number of serial cycles needed for a full-width product.
    function automatic int spm_cycles(input int xw, input int yw);
        return xw + yw;
    endfunction

    // Counter width able to hold 0..spm_cycles().
    function automatic int spm_cnt_w(input int xw, input int yw);
        return $clog2(spm_cycles(xw, yw) + 1);
    endfunction

    localparam int SPM_CNT_W_DEF = spm_cnt_w(8, 8);

endpackage

// File: rtl/spm_csa_cell.sv
// One carry-save cell of the serial-parallel multiplier chain.
// TCMP=1 turns it into the two's-complement top cell: the partial product
// is inverted and the +1 correction arrives on i_inj.
module spm_csa_cell #(
    parameter bit TCMP = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_x,
    input  logic i_y,
    input  logic i_s_in,
    input  logic i_inj,
    output logic o_s,
    output logic o_s_nxt
);

    logic       r_s;
    logic       r_c;
    logic       w_pp;
    logic [1:0] w_sum;

    // Partial product and full add of neighbour sum, own carry and correction.
    always_comb begin
        w_pp  = (i_x & i_y) ^ TCMP;
        w_sum = {1'b0, i_s_in} + {1'b0, w_pp} + {1'b0, r_c} + {1'b0, i_inj};
    end

    // Sum/carry flops: async clear, sync clear on accepted start, update in RUN.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s <= 1'b0;
            r_c <= 1'b0;
        end else if (i_clr) begin
            r_s <= 1'b0;
            r_c <= 1'b0;
        end else if (i_en) begin
            {r_c, r_s} <= w_sum;
        end
    end

    assign o_s     = r_s;
    assign o_s_nxt = w_sum[0];

endmodule

// File: rtl/spm_mult_seq.sv
// Serial-parallel multiplier with start/done handshake and parallel result capture.
module spm_mult_seq
    import spm_pkg::*;
#(
    parameter int XW     = 8,
    parameter int YW     = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [XW-1:0]        i_x,
    input  logic [YW-1:0]        i_y,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [XW+YW-1:0]     o_p
);

    localparam int             N    = spm_cycles(XW, YW);
    localparam int             CW   = spm_cnt_w(XW, YW);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    spm_state_t    r_state;
    spm_state_t    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_ysr;
    logic [N-2:0]  r_psr;
    logic [N-1:0]  r_p;
    logic          w_accept;
    logic          w_run;
    logic          w_first;
    logic          w_ybit;
    logic [N-1:0]  w_psr_nxt;
    logic [XW:0]   w_s;
    logic [XW-1:0] w_s_nxt;
    logic          w_unused_bits;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        w_accept    = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                o_busy = 1'b1;
                w_run  = 1'b1;
                if (r_cnt == LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                o_busy      = 1'b1;
                o_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // y_sr shifts in its own sign (or zero), so bit 0 already supplies the
    // replicated extension once the YW real bits are exhausted.
    always_comb begin
        w_first   = (r_cnt == '0);
        w_ybit    = r_ysr[0];
        w_psr_nxt = {w_s_nxt[0], r_psr};
    end

    // Operand capture, serial counter, product shift register and result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_x   <= '0;
            r_ysr <= '0;
            r_psr <= '0;
            r_p   <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_x   <= i_x;
            r_ysr <= i_y;
            r_psr <= '0;
        end else if (w_run) begin
            r_cnt <= r_cnt + 1'b1;
            r_ysr <= {SIGNED & r_ysr[YW-1], r_ysr[YW-1:1]};
            r_psr <= w_psr_nxt[N-1:1];
            if (r_cnt == LAST) begin
                r_p <= w_psr_nxt;
            end
        end
    end

    assign w_s[XW] = 1'b0;

    for (genvar i = 0; i < XW; i++) begin : g_cell
        localparam bit TOP = SIGNED && (i == XW - 1);
        spm_csa_cell #(
            .TCMP(TOP)
        ) u_cell (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_clr   (w_accept),
            .i_en    (w_run),
            .i_x     (r_x[i]),
            .i_y     (w_ybit),
            .i_s_in  (w_s[i+1]),
            .i_inj   (TOP ? w_first : 1'b0),
            .o_s     (w_s[i]),
            .o_s_nxt (w_s_nxt[i])
        );
    end

    // Only cell 0's next-sum leaves the chain; its registered copy is internal.
    assign w_unused_bits = ^{w_s[0], w_s_nxt[XW-1:1]};

    assign o_p = r_p;

endmodule

// File: tb/tb_spm_mult_seq.sv
// Bench for spm_mult_seq: six configurations checked every cycle against a
// product/timing model, plus directed vectors with literal expectations.
module tb_spm_mult_seq;

    localparam int NI         = 6;
    localparam int XWS [NI]   = '{8, 8, 4, 4, 16, 16};
    localparam int YWS [NI]   = '{8, 8, 12, 12, 3, 3};
    localparam bit SGS [NI]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    logic              clk = 1'b0;
    logic [NI-1:0]     rst_v;
    logic [NI-1:0]     start_v;
    logic [NI-1:0]     busy_v;
    logic [NI-1:0]     done_v;
    logic [NI*16-1:0]  x_v;
    logic [NI*12-1:0]  y_v;
    logic [NI*19-1:0]  p_v;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int XW = XWS[g];
        localparam int YW = YWS[g];
        localparam bit SG = SGS[g];
        logic [XW+YW-1:0] w_p;
        spm_mult_seq #(
            .XW     (XW),
            .YW     (YW),
            .SIGNED (SG)
        ) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_v[g]),
            .i_start (start_v[g]),
            .i_x     (x_v[g*16 +: XW]),
            .i_y     (y_v[g*12 +: YW]),
            .o_busy  (busy_v[g]),
            .o_done  (done_v[g]),
            .o_p     (w_p)
        );
        assign p_v[g*19 +: 19] = 19'(w_p);
    end

    function automatic void chk(input string nm, input int k, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0d expected=%0d", nm, k, act, exp);
        end
    endfunction

    // Exact product of the operands, interpreted per configuration, modulo 2^(XW+YW).
    function automatic longint mdl_prod(input int k, input logic [15:0] xx, input logic [11:0] yy);
        longint xv, yv, m;
        xv = longint'(xx) & ((longint'(1) << XWS[k]) - 1);
        yv = longint'(yy) & ((longint'(1) << YWS[k]) - 1);
        if (SGS[k] && xv >= (longint'(1) << (XWS[k] - 1))) xv -= longint'(1) << XWS[k];
        if (SGS[k] && yv >= (longint'(1) << (YWS[k] - 1))) yv -= longint'(1) << YWS[k];
        m = (longint'(1) << (XWS[k] + YWS[k])) - 1;
        return (xv * yv) & m;
    endfunction

    // Model: an accepted op keeps the unit busy for N+1 cycles, the last being done.
    int     left_m [NI];
    longint pend_m [NI];
    longint p_m    [NI];

    initial begin
        for (int k = 0; k < NI; k++) begin
            left_m[k] = 0;
            pend_m[k] = 0;
            p_m[k]    = 0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (!rst_v[k]) begin
                left_m[k] = 0;
                p_m[k]    = 0;
            end else if (left_m[k] == 0) begin
                if (start_v[k]) begin
                    left_m[k] = XWS[k] + YWS[k] + 1;
                    pend_m[k] = mdl_prod(k, x_v[k*16 +: 16], y_v[k*12 +: 12]);
                end
            end else begin
                if (left_m[k] == 2) p_m[k] = pend_m[k];
                left_m[k] = left_m[k] - 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            longint eb, ed, ep;
            if (!rst_v[k]) begin
                eb = 0; ed = 0; ep = 0;
            end else begin
                eb = (left_m[k] != 0) ? 1 : 0;
                ed = (left_m[k] == 1) ? 1 : 0;
                ep = p_m[k];
            end
            chk("busy", k, longint'(busy_v[k]), eb);
            chk("done", k, longint'(done_v[k]), ed);
            chk("p",    k, longint'(p_v[k*19 +: 19]), ep);
        end
    end

    task automatic wait_done(input int k, output int lat, output bit allbusy);
        lat     = 0;
        allbusy = 1'b1;
        do begin
            @(posedge clk);
            lat++;
            #1;
            start_v[k] = 1'b0;
            if (!busy_v[k]) allbusy = 1'b0;
        end while (!done_v[k] && lat < 100);
        chk("op_done", k, longint'(done_v[k]), 1);
    endtask

    task automatic run_op(input int k, input logic [15:0] xx, input logic [11:0] yy,
                          output int lat, output bit allbusy, output longint pr);
        @(negedge clk);
        x_v[k*16 +: 16] = xx;
        y_v[k*12 +: 12] = yy;
        start_v[k]      = 1'b1;
        wait_done(k, lat, allbusy);
        pr = longint'(p_v[k*19 +: 19]);
        @(posedge clk);
    endtask

    initial begin
        int     lat;
        bit     ab;
        longint pr;
        int     d1, d2;
        int     dc [NI];
        bit     all;

        rst_v   = '1;
        start_v = '0;
        x_v     = '0;
        y_v     = '0;
        #1 rst_v = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_v = '1;
        #1;
        chk("rst_busy", 0, longint'(busy_v[0]), 0);
        chk("rst_done", 0, longint'(done_v[0]), 0);
        chk("rst_p",    0, longint'(p_v[0 +: 19]), 0);

        run_op(0, 16'd13, 12'd11, lat, ab, pr);
        chk("lat_13x11", 0, lat, 17);
        chk("busy_thru", 0, longint'(ab), 1);
        chk("p_13x11",   0, pr, 143);

        run_op(0, 16'd255, 12'd255, lat, ab, pr);
        chk("p_255x255", 0, pr, 65025);
        run_op(0, 16'd0, 12'd200, lat, ab, pr);
        chk("p_0x200", 0, pr, 0);

        run_op(1, 16'h00FD, 12'h007, lat, ab, pr);
        chk("p_m3x7", 1, pr, 16'hFFEB);
        run_op(1, 16'h0080, 12'h080, lat, ab, pr);
        chk("p_m128xm128", 1, pr, 16'h4000);

        // start while busy is ignored
        @(negedge clk);
        x_v[0 +: 16] = 16'd13;
        y_v[0 +: 12] = 12'd11;
        start_v[0]   = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        x_v[0 +: 16] = 16'd1;
        y_v[0 +: 12] = 12'd1;
        start_v[0]   = 1'b1;
        wait_done(0, lat, ab);
        chk("p_ignored", 0, longint'(p_v[0 +: 19]), 143);
        @(posedge clk);

        // continuous start: done pulses N+2 apart
        @(negedge clk);
        x_v[0 +: 16] = 16'd5;
        y_v[0 +: 12] = 12'd6;
        start_v[0]   = 1'b1;
        d1 = 0;
        d2 = 0;
        for (int c = 1; c <= 100 && d2 == 0; c++) begin
            @(posedge clk); #1;
            if (done_v[0]) begin
                if (d1 == 0) d1 = c;
                else         d2 = c;
            end
        end
        start_v[0] = 1'b0;
        chk("b2b_first", 0, d1, 17);
        chk("b2b_gap",   0, d2 - d1, 18);
        chk("b2b_p",     0, longint'(p_v[0 +: 19]), 30);
        for (int c = 0; c < 40 && busy_v[0]; c++) @(posedge clk);
        #1 chk("b2b_idle", 0, longint'(busy_v[0]), 0);

        // reset at cnt=5 aborts immediately
        @(negedge clk);
        x_v[0 +: 16] = 16'd200;
        y_v[0 +: 12] = 12'd3;
        start_v[0]   = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_v[0] = 1'b0;
        #1;
        chk("abort_busy", 0, longint'(busy_v[0]), 0);
        chk("abort_done", 0, longint'(done_v[0]), 0);
        chk("abort_p",    0, longint'(p_v[0 +: 19]), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_v[0] = 1'b1;
        run_op(0, 16'd200, 12'd3, lat, ab, pr);
        chk("p_after_rst", 0, pr, 600);

        // random ops on the narrow/wide configurations, all in parallel
        for (int k = 0; k < NI; k++) dc[k] = 0;
        for (int cyc = 0; cyc < 40000; cyc++) begin
            @(negedge clk);
            all = 1'b1;
            for (int k = 2; k < NI; k++) begin
                if (done_v[k]) dc[k]++;
                if (dc[k] < 1000) begin
                    all             = 1'b0;
                    start_v[k]      = 1'($urandom_range(0, 1));
                    x_v[k*16 +: 16] = 16'($urandom);
                    y_v[k*12 +: 12] = 12'($urandom);
                end else begin
                    start_v[k] = 1'b0;
                end
            end
            if (all) break;
        end
        for (int k = 2; k < NI; k++) chk("rand_ops", k, dc[k], 1000);
        repeat (25) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
